br_resolve: RTL and testbench
=============================

Name: br_resolve

Overview:
- Resolution-side counterpart to the IF-stage direction predictor.
- Carries each fetched instruction's prediction (taken bit plus predicted target) down the IF->ID->EX pipeline, honouring stalls and flushes.
- In EX, compares the prediction against the actual outcome. Drives the predictor update port (update/br_en), issues a redirect to fetch through a valid/ready handshake, and squashes wrong-path instructions.

Parameters:
- PC_RST, 32'h00000060, value loaded into redirect_pc at reset.
- s_ctr, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- stall_id  in  1  hold the ID-stage prediction register
- stall_ex  in  1  hold the EX-stage prediction register; no resolution while high
- if_valid  in  1  an instruction is leaving IF this cycle
- if_pc  in  32  PC of the IF instruction
- if_pred_take  in  1  predictor taken bit for if_pc
- if_pred_target  in  32  predicted target for if_pc
- ex_is_br  in  1  EX instruction is a conditional branch
- ex_is_jmp  in  1  EX instruction is jal/jalr
- ex_br_en  in  1  actual branch condition result
- ex_target  in  32  computed branch/jump target
- pred_update  out  1  predictor update strobe
- pred_br_en  out  1  actual outcome sent to the predictor
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  32  redirect destination
- redirect_ready  in  1  fetch accepts the redirect
- flush_if_id  out  1  squash the IF/ID stage
- flush_id_ex  out  1  squash the ID/EX stage
- mispred  out  1  single-cycle mispredict indication
- br_cnt  out  s_ctr  resolved conditional branches (optional feature)
- mispred_cnt  out  s_ctr  mispredictions (optional feature)

Behaviour:
- Prediction packet: {valid, pc, pred_take, pred_target}.
  - IF->ID register: loaded with the IF packet unless stall_id; valid comes from if_valid.
  - ID->EX register: loaded with the ID packet unless stall_ex.
  - Flush clears the valid bit of the corresponding register regardless of stall; flush has priority.
- Reset (asynchronous): all packet valid bits 0, FSM to IDLE, redirect_valid=0, redirect_pc=PC_RST, counters 0. All other outputs 0.
- Resolution occurs in cycle T when EX valid, !stall_ex and FSM=IDLE.
  - actual_next = (ex_is_jmp | (ex_is_br & ex_br_en)) ? ex_target : pc+4
  - pred_next = pred_take ? pred_target : pc+4
  - Addition is 32-bit and wraps modulo 2^32.
  - mismatch = actual_next != pred_next
  - A non-branch, non-jump instruction with pred_take=1 (aliasing) is a mismatch that redirects to pc+4.
- Combinational outputs in cycle T:
  - pred_update = ex_is_br; pred_br_en = ex_br_en.
  - Jumps and non-branches never update the predictor.
  - mispred = mismatch.
  - flush_if_id = flush_id_ex = mismatch.
- FSM states: IDLE, REDIRECT.
  - IDLE -> REDIRECT on mismatch. redirect_pc <= actual_next, registered.
  - REDIRECT: redirect_valid=1; redirect_pc held stable; flush_if_id and flush_id_ex held 1 every cycle; no resolution and no pred_update.
  - REDIRECT -> IDLE in the cycle redirect_valid & redirect_ready; redirect_valid=0 from the next cycle.
  - Latency: detection at T gives redirect_valid at T+1 at the earliest; the handshake can complete at T+1.
- Stall interaction: stall_ex=1 in IDLE suppresses resolution. The packet is held and resolved on the first unstalled cycle, exactly once.
- redirect_ready while redirect_valid=0 is ignored.
- Reset asserted during REDIRECT drops redirect_valid immediately; no handshake completes.

Optional Feature:
- Macro: BR_PERF_CNT_EN.
- Defined:
  - br_cnt increments on every cycle with pred_update=1.
  - mispred_cnt increments on every cycle with mispred=1.
  - Both saturate at all-ones; neither wraps.
- Undefined: br_cnt and mispred_cnt are tied to 0 and no counter flops are built.

Test Plan:
- Correct taken prediction: pc=0x100, pred_take=1, pred_target=0x80, br_en=1, target=0x80 -> pred_update=1, pred_br_en=1, mispred=0, no redirect, no flush.
- Wrong not-taken prediction: pc=0x200, pred_take=0, br_en=1, target=0x240, redirect_ready=1 -> cycle T: mispred=1, both flushes=1. Cycle T+1: redirect_valid=1, redirect_pc=0x240. Cycle T+2: redirect_valid=0.
- Backpressure: same mismatch with redirect_ready=0 for 3 cycles -> redirect_valid, redirect_pc and both flushes held 3 cycles; redirect_valid drops the cycle after ready=1; a valid EX packet during REDIRECT gives pred_update=0.
- Stall: stall_ex=1 for 2 cycles with a mispredicting branch in EX -> no update or mispred during the stall; exactly one pred_update/mispred pulse on release.
- Jump and aliasing: jal at 0x300, pred_take=0, target=0x400 -> redirect to 0x400, pred_update=0. Non-branch at 0x500 with pred_take=1 -> redirect to 0x504.
- Reset mid-redirect, plus counters: assert rst while in REDIRECT -> redirect_valid=0 immediately, redirect_pc=PC_RST. With BR_PERF_CNT_EN: 5 branches with 2 mispredictions -> br_cnt=5, mispred_cnt=2. Preloading br_cnt to max then resolving one more branch -> br_cnt stays at max.

Source files
------------

// File: rtl/br_resolve.sv
// Branch resolution: carries IF predictions to EX, resolves them, and drives predictor
// update, fetch redirect handshake and pipeline squash. Optional counters: BR_PERF_CNT_EN.
module br_resolve #(
  parameter logic [31:0] PC_RST = 32'h00000060,
  parameter int          s_ctr  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_id,
  input  logic             stall_ex,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_take,
  input  logic [31:0]      if_pred_target,
  input  logic             ex_is_br,
  input  logic             ex_is_jmp,
  input  logic             ex_br_en,
  input  logic [31:0]      ex_target,
  output logic             pred_update,
  output logic             pred_br_en,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             mispred,
  output logic [s_ctr-1:0] br_cnt,
  output logic [s_ctr-1:0] mispred_cnt
);

  typedef enum logic {IDLE, REDIRECT} state_e;

  state_e      state_q, state_d;
  logic        id_valid_q, id_take_q, ex_valid_q, ex_take_q;
  logic [31:0] id_pc_q, id_tgt_q, ex_pc_q, ex_tgt_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] pc_plus4, actual_next, pred_next;
  logic        resolve, mismatch;

  // Flush only kills the valid bit; payload follows the stall controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_take_q  <= 1'b0;
      id_tgt_q   <= '0;
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_take_q  <= 1'b0;
      ex_tgt_q   <= '0;
    end else begin
      if (flush_if_id)   id_valid_q <= 1'b0;
      else if (!stall_id) id_valid_q <= if_valid;
      if (!stall_id) begin
        id_pc_q   <= if_pc;
        id_take_q <= if_pred_take;
        id_tgt_q  <= if_pred_target;
      end
      if (flush_id_ex)   ex_valid_q <= 1'b0;
      else if (!stall_ex) ex_valid_q <= id_valid_q;
      if (!stall_ex) begin
        ex_pc_q   <= id_pc_q;
        ex_take_q <= id_take_q;
        ex_tgt_q  <= id_tgt_q;
      end
    end
  end

  always_comb begin
    pc_plus4    = ex_pc_q + 32'd4;
    actual_next = (ex_is_jmp | (ex_is_br & ex_br_en)) ? ex_target : pc_plus4;
    pred_next   = ex_take_q ? ex_tgt_q : pc_plus4;
    resolve     = ex_valid_q & ~stall_ex & (state_q == IDLE);
    mismatch    = resolve & (actual_next != pred_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (mismatch) state_d = REDIRECT;
      REDIRECT: if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    pred_update    = resolve & ex_is_br;
    pred_br_en     = resolve & ex_br_en;
    mispred        = mismatch;
    redirect_valid = (state_q == REDIRECT);
    flush_if_id    = mismatch | (state_q == REDIRECT);
    flush_id_ex    = mismatch | (state_q == REDIRECT);
    redirect_pc    = redirect_pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           redirect_pc_q <= PC_RST;
    else if (mismatch) redirect_pc_q <= actual_next;
  end

`ifdef BR_PERF_CNT_EN
  logic [s_ctr-1:0] br_cnt_q, mispred_cnt_q;

  // Saturating: a stuck-at-max counter is more useful than a wrapped one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (pred_update && !(&br_cnt_q))  br_cnt_q      <= br_cnt_q + 1'b1;
      if (mispred && !(&mispred_cnt_q)) mispred_cnt_q <= mispred_cnt_q + 1'b1;
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  assign br_cnt      = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Scoreboard bench for br_resolve: expected resolution pushed at IF, checked at EX.
module tb_br_resolve;
  localparam int SC = 3;
  localparam logic [31:0] PC_RST = 32'h00000060;

  logic clk = 1'b0;
  logic rst, stall_id, stall_ex, if_valid, if_pred_take;
  logic [31:0] if_pc, if_pred_target, ex_target, redirect_pc;
  logic ex_is_br, ex_is_jmp, ex_br_en, redirect_ready;
  logic pred_update, pred_br_en, redirect_valid, flush_if_id, flush_id_ex, mispred;
  logic [SC-1:0] br_cnt, mispred_cnt;

  always #5 clk = ~clk;

  br_resolve #(.PC_RST(PC_RST), .s_ctr(SC)) dut (
    .clk(clk), .rst(rst), .stall_id(stall_id), .stall_ex(stall_ex),
    .if_valid(if_valid), .if_pc(if_pc), .if_pred_take(if_pred_take),
    .if_pred_target(if_pred_target), .ex_is_br(ex_is_br), .ex_is_jmp(ex_is_jmp),
    .ex_br_en(ex_br_en), .ex_target(ex_target), .pred_update(pred_update),
    .pred_br_en(pred_br_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .mispred(mispred), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic        upd;
    logic        bren;
    logic        mis;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int model_br = 0;
  int model_mis = 0;
  int max_cnt = (1 << SC) - 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
`ifdef BR_PERF_CNT_EN
    check({tag, "_br_cnt"}, 32'(br_cnt), 32'(model_br));
    check({tag, "_mis_cnt"}, 32'(mispred_cnt), 32'(model_mis));
`else
    check({tag, "_br_cnt"}, 32'(br_cnt), 32'd0);
    check({tag, "_mis_cnt"}, 32'(mispred_cnt), 32'd0);
`endif
  endtask

  task automatic clear_ex();
    ex_is_br = 0; ex_is_jmp = 0; ex_br_en = 0; ex_target = 0;
  endtask

  task automatic run_txn(input logic [31:0] pc, input logic take, input logic [31:0] tgt,
                         input logic is_br, input logic is_jmp, input logic bren,
                         input logic [31:0] target, input int stalls, input int rdelay,
                         input bit do_reset);
    exp_t e, g;
    logic [31:0] act, prd;
    act = (is_jmp | (is_br & bren)) ? target : pc + 32'd4;
    prd = take ? tgt : pc + 32'd4;
    e.upd = is_br; e.bren = bren; e.mis = (act != prd); e.rpc = act;
    sb.push_back(e);

    @(negedge clk);
    if_valid = 1; if_pc = pc; if_pred_take = take; if_pred_target = tgt; clear_ex();
    #1 check("if_upd", 32'(pred_update), 32'd0);
    @(negedge clk);
    if_valid = 0;
    for (int s = 0; s < stalls; s++) begin
      @(negedge clk);
      stall_ex = 1; ex_is_br = is_br; ex_is_jmp = is_jmp; ex_br_en = bren; ex_target = target;
      #1 check("stall_upd", 32'(pred_update), 32'd0);
      check("stall_mis", 32'(mispred), 32'd0);
    end
    @(negedge clk);
    stall_ex = 0; ex_is_br = is_br; ex_is_jmp = is_jmp; ex_br_en = bren; ex_target = target;
    #1;
    g = sb.pop_front();
    check("upd", 32'(pred_update), 32'(g.upd));
    if (g.upd) check("br_en", 32'(pred_br_en), 32'(g.bren));
    check("mis", 32'(mispred), 32'(g.mis));
    check("fl_ifid", 32'(flush_if_id), 32'(g.mis));
    check("fl_idex", 32'(flush_id_ex), 32'(g.mis));
    if (g.upd && model_br < max_cnt) model_br++;
    if (g.mis && model_mis < max_cnt) model_mis++;
    $display("txn pc=%h br=%0b jmp=%0b upd=%0b mis=%0b rpc=%h", pc, is_br, is_jmp,
             pred_update, mispred, g.rpc);

    @(negedge clk);
    clear_ex();
    if (!g.mis) begin
      #1 check("no_rv", 32'(redirect_valid), 32'd0);
      check("no_fl", 32'(flush_if_id), 32'd0);
      check_cnt("txn");
      return;
    end
    if (do_reset) begin
      redirect_ready = 0;
      #1 check("pre_rst_rv", 32'(redirect_valid), 32'd1);
      rst = 1;
      #1 check("rst_rv", 32'(redirect_valid), 32'd0);
      check("rst_rpc", redirect_pc, PC_RST);
      check("rst_fl", 32'(flush_id_ex), 32'd0);
      model_br = 0; model_mis = 0;
      check_cnt("rst");
      @(negedge clk);
      rst = 0;
      return;
    end
    // A branch presented during REDIRECT must not update the predictor.
    ex_is_br = 1; ex_br_en = 1;
    for (int k = 0; k < rdelay; k++) begin
      redirect_ready = 0;
      #1 check("bp_rv", 32'(redirect_valid), 32'd1);
      check("bp_rpc", redirect_pc, g.rpc);
      check("bp_fl_ifid", 32'(flush_if_id), 32'd1);
      check("bp_fl_idex", 32'(flush_id_ex), 32'd1);
      check("bp_upd", 32'(pred_update), 32'd0);
      @(negedge clk);
    end
    redirect_ready = 1;
    #1 check("rv", 32'(redirect_valid), 32'd1);
    check("rpc", redirect_pc, g.rpc);
    check("rd_upd", 32'(pred_update), 32'd0);
    @(negedge clk);
    redirect_ready = 0; clear_ex();
    #1 check("rv_drop", 32'(redirect_valid), 32'd0);
    check("fl_drop", 32'(flush_if_id), 32'd0);
    check_cnt("txn");
  endtask

  initial begin
    rst = 1; stall_id = 0; stall_ex = 0; if_valid = 0; if_pc = 0; if_pred_take = 0;
    if_pred_target = 0; redirect_ready = 0; clear_ex();
    @(negedge clk);
    #1 check("r_rv", 32'(redirect_valid), 32'd0);
    check("r_rpc", redirect_pc, PC_RST);
    check("r_upd", 32'(pred_update), 32'd0);
    check("r_mis", 32'(mispred), 32'd0);
    check("r_fl", 32'(flush_if_id), 32'd0);
    check_cnt("r");
    @(negedge clk);
    rst = 0;

    // pc, take, tgt, is_br, is_jmp, br_en, target, stalls, rdelay, reset
    run_txn(32'h100, 1, 32'h80,  1, 0, 1, 32'h80,  0, 0, 0);
    run_txn(32'h200, 0, 32'h0,   1, 0, 1, 32'h240, 0, 0, 0);
    run_txn(32'h200, 0, 32'h0,   1, 0, 1, 32'h240, 0, 3, 0);
    run_txn(32'h220, 1, 32'h180, 1, 0, 0, 32'h180, 2, 0, 0);
    run_txn(32'h300, 0, 32'h0,   0, 1, 0, 32'h400, 0, 0, 0);
    run_txn(32'h500, 1, 32'h700, 0, 0, 0, 32'h0,   0, 1, 0);
    run_txn(32'hFFFFFFFC, 0, 32'h0, 1, 0, 0, 32'h10, 0, 0, 0);
    run_txn(32'h600, 0, 32'h0,   1, 0, 1, 32'h640, 0, 1, 1);

    // Five branches, two mispredicted, then enough to saturate the 3-bit counter.
    run_txn(32'h1000, 1, 32'h1100, 1, 0, 1, 32'h1100, 0, 0, 0);
    run_txn(32'h1010, 0, 32'h0,    1, 0, 1, 32'h1200, 0, 0, 0);
    run_txn(32'h1020, 0, 32'h0,    1, 0, 0, 32'h1300, 0, 0, 0);
    run_txn(32'h1030, 1, 32'h1400, 1, 0, 0, 32'h1400, 0, 0, 0);
    run_txn(32'h1040, 1, 32'h1500, 1, 0, 1, 32'h1500, 0, 0, 0);
`ifdef BR_PERF_CNT_EN
    check("five_br", 32'(br_cnt), 32'd5);
    check("two_mis", 32'(mispred_cnt), 32'd2);
`endif
    for (int i = 0; i < 4; i++)
      run_txn(32'h2000 + 32'(i * 16), 0, 32'h0, 1, 0, 0, 32'h3000, 0, 0, 0);
`ifdef BR_PERF_CNT_EN
    check("sat_br", 32'(br_cnt), 32'(max_cnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
